// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage A registers the bit-level g/p and the 4-bit group G/P. Stage B resolves every
// group carry-in with a second lookahead level, then every bit carry within each group.
// Stage B is the output register.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            operand handshake
//   in_a, in_b, in_cin, in_sub   operands; in_sub=1 gives a-b and ignores in_cin
//   out_valid/out_ready          result handshake
//   out_sum, out_cout, out_ovf   result, carry out of the MSB, signed overflow
//   out_gout, out_pout           whole-word generate/propagate for a further lookahead level
module cla_add_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_gout,
  output logic             out_pout
);

  localparam int unsigned NG = WIDTH / 4;

  generate
    if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH % 4) != 0)) begin : g_bad_width
      $error("cla_add_pipe: WIDTH must be a multiple of 4 in the range 4..64");
    end
  endgenerate

  // AND of group propagates over groups lo..hi; an empty range yields 1.
  function automatic logic span(input logic [NG-1:0] pv, input int lo, input int hi);
    logic [NG-1:0] m;
    for (int i = 0; i < int'(NG); i++) begin
      m[i] = ((i >= lo) && (i <= hi)) ? pv[i] : 1'b1;
    end
    return &m;
  endfunction

  // Handshake
  logic a_valid;
  logic ready_a;
  logic ready_b;

  assign ready_b  = !out_valid || out_ready;
  assign ready_a  = !a_valid || ready_b;
  assign in_ready = ready_a && !rst;

  // Stage A combinational: operand conditioning, bit and group generate/propagate
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g_n;
  logic [WIDTH-1:0] p_n;
  logic [NG-1:0]    gg_n;
  logic [NG-1:0]    gp_n;
  logic             c0_n;

  always_comb begin
    bx   = in_sub ? ~in_b : in_b;
    c0_n = in_sub | in_cin;
    g_n  = in_a & bx;
    p_n  = in_a ^ bx;
    gg_n = '0;
    gp_n = '0;
    for (int k = 0; k < int'(NG); k++) begin
      gg_n[k] = g_n[4*k+3]
              | (p_n[4*k+3] & g_n[4*k+2])
              | (p_n[4*k+3] & p_n[4*k+2] & g_n[4*k+1])
              | (p_n[4*k+3] & p_n[4*k+2] & p_n[4*k+1] & g_n[4*k]);
      gp_n[k] = &p_n[4*k +: 4];
    end
  end

  // Stage A registers
  logic [WIDTH-1:0] a_g;
  logic [WIDTH-1:0] a_p;
  logic [NG-1:0]    a_gg;
  logic [NG-1:0]    a_gp;
  logic             a_c0;

  // Stage B combinational: group carries, bit carries, sum and flags
  logic [NG-1:0]    cg;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_n;
  logic             gout_n;
  logic             pout_n;
  logic             cout_n;
  logic             ovf_n;

  always_comb begin
    cg = '0;
    c  = '0;
    // Each group carry-in is a flat sum of products over lower groups' G/P and c0.
    for (int k = 0; k < int'(NG); k++) begin
      cg[k] = a_c0 & span(a_gp, 0, k - 1);
      for (int j = 0; j < k; j++) begin
        cg[k] = cg[k] | (a_gg[j] & span(a_gp, j + 1, k - 1));
      end
    end
    for (int k = 0; k < int'(NG); k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = a_g[4*k] | (a_p[4*k] & cg[k]);
      c[4*k+2] = a_g[4*k+1]
               | (a_p[4*k+1] & a_g[4*k])
               | (a_p[4*k+1] & a_p[4*k] & cg[k]);
      c[4*k+3] = a_g[4*k+2]
               | (a_p[4*k+2] & a_g[4*k+1])
               | (a_p[4*k+2] & a_p[4*k+1] & a_g[4*k])
               | (a_p[4*k+2] & a_p[4*k+1] & a_p[4*k] & cg[k]);
    end
    sum_n  = a_p ^ c;
    gout_n = 1'b0;
    for (int j = 0; j < int'(NG); j++) begin
      gout_n = gout_n | (a_gg[j] & span(a_gp, j + 1, int'(NG) - 1));
    end
    pout_n = &a_p;
    cout_n = gout_n | (pout_n & a_c0);
    ovf_n  = c[WIDTH-1] ^ cout_n;
  end

  // Pipeline registers; data only loads on a valid beat so out_* hold across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_g       <= '0;
      a_p       <= '0;
      a_gg      <= '0;
      a_gp      <= '0;
      a_c0      <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_gout  <= 1'b0;
      out_pout  <= 1'b0;
    end else begin
      if (ready_a) begin
        a_valid <= in_valid;
        if (in_valid) begin
          a_g  <= g_n;
          a_p  <= p_n;
          a_gg <= gg_n;
          a_gp <= gp_n;
          a_c0 <= c0_n;
        end
      end
      if (ready_b) begin
        out_valid <= a_valid;
        if (a_valid) begin
          out_sum  <= sum_n;
          out_cout <= cout_n;
          out_ovf  <= ovf_n;
          out_gout <= gout_n;
          out_pout <= pout_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_add_pipe.sv
// Bench for cla_add_pipe (WIDTH=32): directed vector table, latency, stall/ordering,
// mid-stream reset and random traffic, all checked through an expected-result queue.
module tb_cla_add_pipe;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         gout;
    logic         pout;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    exp_t         e;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_gout;
  logic         out_pout;

  int total;
  int bad;
  int n_in;
  int n_out;
  exp_t q[$];

  cla_add_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_gout(out_gout), .out_pout(out_pout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t r;
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   full;
    logic [W:0]   nocin;
    logic [W-1:0] low;
    bb     = sub ? ~b : b;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + (W+1)'(c0);
    nocin  = {1'b0, a} + {1'b0, bb};
    low    = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + W'(c0);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = low[W-1] ^ full[W];
    r.gout = nocin[W];
    r.pout = &(a ^ bb);
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                              input logic sub, input logic [W-1:0] s, input logic co,
                              input logic ov, input logic go, input logic po);
    vec_t v;
    v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.e.sum = s; v.e.cout = co; v.e.ovf = ov; v.e.gout = go; v.e.pout = po;
    return v;
  endfunction

  // Output side: every visible result must equal the queue head, including while stalled.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 64'({out_sum, out_cout, out_ovf, out_gout, out_pout}), 64'hDEAD);
      end else begin
        chk("result", 64'({out_sum, out_cout, out_ovf, out_gout, out_pout}), 64'(q[0]));
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
  end

  // Offer one beat and hold it until accepted; returns at the negedge of acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input exp_t e);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        n_in++;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          total++; bad++;
          $display("FAIL accept_timeout: in_ready stuck low");
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic drain();
    int waits;
    waits = 0;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 100) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d beats still pending", q.size());
    end
  endtask

  vec_t tbl[9];

  initial begin
    int   nxt;
    int   sent;
    int   guard;
    bit   pending;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    total = 0; bad = 0; n_in = 0; n_out = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;

    tbl[0] = mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[3] = mk(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[5] = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[7] = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[8] = mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({out_valid, out_sum, out_cout, out_ovf, out_gout, out_pout}), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'h1);

    // Latency: accept at edge N, out_valid at edge N+2
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h0000_0003; in_b = 32'h0000_0004; in_cin = 1'b1; in_sub = 1'b0;
    @(negedge clk);
    chk("lat_accept", 64'(in_ready), 64'h1);
    if (in_ready) begin
      q.push_back(model(in_a, in_b, in_cin, in_sub));
      n_in++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n_plus_1", 64'(out_valid), 64'h0);
    @(negedge clk);
    chk("lat_n_plus_2", 64'(out_valid), 64'h1);
    drain();

    // Directed table, back to back
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].e);
    end
    drain();

    // Stall: two beats buffered, then in_ready drops; release streams 2,4,6,8
    @(posedge clk); #1;
    out_ready = 1'b0;
    nxt = 1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = W'(nxt); in_b = W'(nxt); in_cin = 1'b0; in_sub = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        e = '0; e.sum = W'(2 * nxt);
        q.push_back(e);
        n_in++;
        nxt++;
      end
    end
    chk("stall_accepted", 64'(nxt - 1), 64'd2);
    chk("stall_in_ready", 64'(in_ready), 64'h0);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (nxt <= 4);
      in_a = W'(nxt); in_b = W'(nxt);
      @(negedge clk);
      chk("stream_valid", 64'(out_valid), 64'h1);
      if (in_valid && in_ready) begin
        e = '0; e.sum = W'(2 * nxt);
        q.push_back(e);
        n_in++;
        nxt++;
      end
    end
    chk("stream_accepted", 64'(nxt - 1), 64'd4);
    drain();

    // Reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send(W'(32'h100 + i), W'(32'h10), 1'b0, 1'b0, model(W'(32'h100 + i), W'(32'h10), 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      if (i > 0) begin
        chk("rst_outputs", 64'({out_valid, out_sum, out_cout, out_ovf, out_gout, out_pout}), 64'h0);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n_in = n_out;
    @(negedge clk);
    chk("rst_release_ready", 64'(in_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 64'(out_valid), 64'h0);
    end

    // Random traffic with random backpressure
    sent = 0; guard = 0; pending = 1'b0;
    while (sent < 3000 && guard < 40000) begin
      guard++;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending) begin
        in_valid = 1'b0;
        if ($urandom_range(0, 4) != 0) begin
          case ($urandom_range(0, 7))
            0: ra = '0;
            1: ra = '1;
            2: ra = 32'h7FFF_FFFF;
            3: ra = 32'h8000_0000;
            default: ra = $urandom;
          endcase
          rb = ($urandom_range(0, 5) == 0) ? ~ra : W'($urandom);
          in_a = ra; in_b = rb;
          in_cin = 1'($urandom_range(0, 1));
          in_sub = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          pending  = 1'b1;
        end
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_cin, in_sub));
        n_in++;
        sent++;
        pending = 1'b0;
      end
    end
    if (guard >= 40000) begin
      total++; bad++;
      $display("FAIL random_timeout: sent=%0d", sent);
    end
    drain();
    chk("beat_count", 64'(n_out), 64'(n_in));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
